// File: rtl/riscv_v_uop_seq.sv
// riscv_v_uop_seq
// ---------------
// Vector micro-op sequencer between the scalar ID stage and vector EXE.
// One vector instruction is accepted at a time and split into one micro-op
// per register of its LMUL group, capped by vl. Vector CSR writes wait
// until earlier micro-ops have left the pipeline (tracked by r_drain).
//
// Optional feature: define RISCV_V_FRAC_LMUL_EN to make fractional LMUL
// (vlmul 5/6/7) legal. Such instructions issue a single micro-op. Without the
// macro, these encodings are illegal.
//
// Handshake: a micro-op is offered while uop_valid_exe is high. It is consumed
// in any cycle where uop_valid_exe & !riscv_stall. An ID instruction is
// accepted in any cycle where
// inst_valid_id & !riscv_v_stall & !riscv_stall & !clear_pipe.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   clear_pipe          flush: drops micro-ops, returns to IDLE
//   riscv_stall         scalar stall: no acceptance, no consumption
//   inst_valid_id       vector instruction present in ID
//   inst_is_csr_id      ID instruction writes a vector CSR
//   vsew, vlmul, vl     current vtype / vector length
//   riscv_v_stall       hold scalar front end (combinational)
//   uop_valid_exe       micro-op presented to EXE
//   uop_idx_exe         register offset within the group
//   uop_last_exe        final micro-op of the instruction
//   illegal_id          one-cycle pulse: ID instruction has an illegal vtype
//   dbg_state           FSM state (0 IDLE, 1 ISSUE, 2 CSR_WAIT)
module riscv_v_uop_seq #(
  parameter int VLEN       = 128,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_pipe,
  input  logic                   riscv_stall,
  input  logic                   inst_valid_id,
  input  logic                   inst_is_csr_id,
  input  logic [2:0]             vsew,
  input  logic [2:0]             vlmul,
  input  logic [$clog2(VLEN):0]  vl,
  output logic                   riscv_v_stall,
  output logic                   uop_valid_exe,
  output logic [2:0]             uop_idx_exe,
  output logic                   uop_last_exe,
  output logic                   illegal_id,
  output logic [1:0]             dbg_state
);

  localparam int VLW      = $clog2(VLEN) + 1;
  localparam int DW       = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);
  localparam int EPR_BASE = $clog2(VLEN / 8);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_CSR_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_valid;
  logic [2:0]      r_idx;
  logic            r_last;
  logic            r_illegal;
  logic [3:0]      r_n;
  logic [DW-1:0]   r_drain;

  state_t          w_next_state;
  logic            w_next_valid;
  logic [2:0]      w_next_idx;
  logic            w_next_last;
  logic            w_next_illegal;
  logic [3:0]      w_next_n;
  logic [DW-1:0]   w_next_drain;

  logic [3:0]      w_epr_log2;
  logic [VLW-1:0]  w_vl_m1;
  logic [VLW-1:0]  w_groups;
  logic [3:0]      w_regs;
  logic [3:0]      w_n;
  logic            w_frac_ok;
  logic            w_legal;
  logic            w_consume;
  logic            w_drain_busy;
  logic            w_csr_block;
  logic            w_accept;

`ifdef RISCV_V_FRAC_LMUL_EN
  assign w_frac_ok = 1'b1;
`else
  assign w_frac_ok = ~vlmul[2];
`endif

  assign w_legal = ~vsew[2] & (vlmul != 3'b100) & w_frac_ok;

  // Micro-op count of the instruction currently in ID.
  always_comb begin
    w_epr_log2 = 4'(EPR_BASE) - {1'b0, vsew};
    w_vl_m1    = vl - VLW'(1);
    w_groups   = (w_vl_m1 >> w_epr_log2) + VLW'(1);
    w_regs     = 4'd1 << vlmul[1:0];
    w_n        = 4'd0;
    if (inst_is_csr_id) begin
      w_n = 4'd1;
    end else if (vl != '0) begin
      if (w_groups > VLW'(w_regs)) w_n = w_regs;
      else                         w_n = w_groups[3:0];
`ifdef RISCV_V_FRAC_LMUL_EN
      if (vlmul[2]) w_n = 4'd1;
`endif
    end
  end

  assign w_consume = (r_state == S_ISSUE) & r_valid & ~riscv_stall;

  // A micro-op consumed this cycle is still in flight for a following CSR
  // write, even though r_drain only reloads at the next edge.
  assign w_drain_busy = (r_drain != '0) | w_consume;
  assign w_csr_block  = inst_valid_id & inst_is_csr_id & w_drain_busy;

  // CSR_WAIT releases the front end in the cycle r_drain reaches zero, which
  // is the cycle the waiting CSR write is accepted.
  assign riscv_v_stall = ((r_state == S_ISSUE) & ~r_last)
                       | ((r_state == S_CSR_WAIT) & (r_drain != '0))
                       | (((r_state == S_IDLE) | ((r_state == S_ISSUE) & r_last))
                          & w_csr_block);

  assign w_accept = inst_valid_id & ~riscv_v_stall & ~riscv_stall & ~clear_pipe;

  always_comb begin
    w_next_state   = r_state;
    w_next_valid   = r_valid;
    w_next_idx     = r_idx;
    w_next_last    = r_last;
    w_next_n       = r_n;
    w_next_illegal = 1'b0;
    if (w_consume)            w_next_drain = DRAIN_LOAD;
    else if (r_drain != '0)   w_next_drain = r_drain - DW'(1);
    else                      w_next_drain = '0;

    if (clear_pipe) begin
      w_next_state = S_IDLE;
      w_next_valid = 1'b0;
      w_next_idx   = 3'd0;
      w_next_last  = 1'b0;
      w_next_drain = '0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (w_consume) begin
            if (r_last) begin
              w_next_state = S_IDLE;
              w_next_valid = 1'b0;
              w_next_idx   = 3'd0;
              w_next_last  = 1'b0;
            end else begin
              w_next_idx  = r_idx + 3'd1;
              w_next_last = ({1'b0, r_idx} == (r_n - 4'd2));
            end
          end
        end
        S_IDLE: begin
          if (inst_valid_id && inst_is_csr_id && (r_drain != '0) && !riscv_stall)
            w_next_state = S_CSR_WAIT;
        end
        S_CSR_WAIT: begin
          // The front end withdrew the instruction (e.g. it was squashed).
          if (!inst_valid_id && !riscv_stall) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase

      // Acceptance overrides the hand-off to IDLE from the last micro-op.
      if (w_accept) begin
        if (!w_legal) begin
          w_next_illegal = 1'b1;
          w_next_state   = S_IDLE;
        end else if (w_n != 4'd0) begin
          w_next_state = S_ISSUE;
          w_next_valid = 1'b1;
          w_next_idx   = 3'd0;
          w_next_last  = (w_n == 4'd1);
          w_next_n     = w_n;
        end else begin
          w_next_state = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_idx     <= 3'd0;
      r_last    <= 1'b0;
      r_illegal <= 1'b0;
      r_n       <= 4'd0;
      r_drain   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_valid   <= w_next_valid;
      r_idx     <= w_next_idx;
      r_last    <= w_next_last;
      r_illegal <= w_next_illegal;
      r_n       <= w_next_n;
      r_drain   <= w_next_drain;
    end
  end

  assign uop_valid_exe = r_valid;
  assign uop_idx_exe   = r_idx;
  assign uop_last_exe  = r_last;
  assign illegal_id    = r_illegal;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_riscv_v_uop_seq.sv
// Directed testbench for riscv_v_uop_seq (VLEN=128, PIPE_DEPTH=3).
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
module tb_riscv_v_uop_seq;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_CSR_WAIT = 2'd2;

  logic       clk;
  logic       rst;
  logic       clear_pipe;
  logic       riscv_stall;
  logic       inst_valid_id;
  logic       inst_is_csr_id;
  logic [2:0] vsew;
  logic [2:0] vlmul;
  logic [7:0] vl;
  logic       riscv_v_stall;
  logic       uop_valid_exe;
  logic [2:0] uop_idx_exe;
  logic       uop_last_exe;
  logic       illegal_id;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  riscv_v_uop_seq #(.VLEN(128), .PIPE_DEPTH(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear_pipe     (clear_pipe),
    .riscv_stall    (riscv_stall),
    .inst_valid_id  (inst_valid_id),
    .inst_is_csr_id (inst_is_csr_id),
    .vsew           (vsew),
    .vlmul          (vlmul),
    .vl             (vl),
    .riscv_v_stall  (riscv_v_stall),
    .uop_valid_exe  (uop_valid_exe),
    .uop_idx_exe    (uop_idx_exe),
    .uop_last_exe   (uop_last_exe),
    .illegal_id     (illegal_id),
    .dbg_state      (dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_inst(input logic v, input logic csr, input logic [2:0] sew,
                          input logic [2:0] lmul, input logic [7:0] len);
    inst_valid_id  = v;
    inst_is_csr_id = csr;
    vsew           = sew;
    vlmul          = lmul;
    vl             = len;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_pipe = 1'b0;
    riscv_stall = 1'b0;
    set_inst(1'b0, 1'b0, 3'd0, 3'd0, 8'd0);
    cyc();
    cyc();
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", uop_valid_exe); end
    n_cmp++; if (uop_idx_exe !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d exp 0", uop_idx_exe); end
    n_cmp++; if (uop_last_exe !== 1'b0) begin n_err++; $display("FAIL reset_last got %b exp 0", uop_last_exe); end
    n_cmp++; if (illegal_id !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b exp 0", illegal_id); end
    n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", riscv_v_stall); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  // vsew=0, vlmul=3, vl=128 -> 8 micro-ops, stall for 7 cycles.
  task automatic test_lmul8();
    set_inst(1'b1, 1'b0, 3'd0, 3'd3, 8'd128);
    smp();
    n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL lmul8_accept_stall got %b exp 0", riscv_v_stall); end
    cyc();
    inst_valid_id = 1'b0;
    for (int k = 0; k < 8; k++) begin
      smp();
      n_cmp++; if (uop_valid_exe !== 1'b1) begin n_err++; $display("FAIL lmul8_valid k=%0d got %b exp 1", k, uop_valid_exe); end
      n_cmp++; if (uop_idx_exe !== 3'(k)) begin n_err++; $display("FAIL lmul8_idx k=%0d got %0d exp %0d", k, uop_idx_exe, k); end
      n_cmp++; if (uop_last_exe !== (k == 7)) begin n_err++; $display("FAIL lmul8_last k=%0d got %b exp %b", k, uop_last_exe, (k == 7)); end
      n_cmp++; if (riscv_v_stall !== (k != 7)) begin n_err++; $display("FAIL lmul8_stall k=%0d got %b exp %b", k, riscv_v_stall, (k != 7)); end
      cyc();
    end
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL lmul8_done_valid got %b exp 0", uop_valid_exe); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL lmul8_done_state got %0d exp %0d", dbg_state, ST_IDLE); end
    cyc();
  endtask

  // vsew=2, vlmul=2, vl=5 -> N=2.
  task automatic test_partial_group();
    set_inst(1'b1, 1'b0, 3'd2, 3'd2, 8'd5);
    cyc();
    inst_valid_id = 1'b0;
    for (int k = 0; k < 2; k++) begin
      smp();
      n_cmp++; if (uop_valid_exe !== 1'b1) begin n_err++; $display("FAIL n2_valid k=%0d got %b exp 1", k, uop_valid_exe); end
      n_cmp++; if (uop_idx_exe !== 3'(k)) begin n_err++; $display("FAIL n2_idx k=%0d got %0d exp %0d", k, uop_idx_exe, k); end
      n_cmp++; if (uop_last_exe !== (k == 1)) begin n_err++; $display("FAIL n2_last k=%0d got %b exp %b", k, uop_last_exe, (k == 1)); end
      cyc();
    end
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL n2_done_valid got %b exp 0", uop_valid_exe); end
    cyc();
  endtask

  // vl=0 -> nothing issued; the next instruction is accepted straight away.
  task automatic test_vl_zero();
    set_inst(1'b1, 1'b0, 3'd0, 3'd0, 8'd0);
    smp();
    n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL vl0_stall got %b exp 0", riscv_v_stall); end
    cyc();
    set_inst(1'b1, 1'b0, 3'd0, 3'd0, 8'd16);
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL vl0_no_uop got %b exp 0", uop_valid_exe); end
    n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL vl0_next_stall got %b exp 0", riscv_v_stall); end
    n_cmp++; if (illegal_id !== 1'b0) begin n_err++; $display("FAIL vl0_illegal got %b exp 0", illegal_id); end
    cyc();
    inst_valid_id = 1'b0;
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b1) begin n_err++; $display("FAIL vl0_follow_valid got %b exp 1", uop_valid_exe); end
    n_cmp++; if (uop_last_exe !== 1'b1) begin n_err++; $display("FAIL vl0_follow_last got %b exp 1", uop_last_exe); end
    cyc();
  endtask

  // Single micro-op consumed at C, CSR write presented from C:
  // stall C..C+3, CSR micro-op at C+5.
  task automatic test_csr_drain();
    set_inst(1'b1, 1'b0, 3'd2, 3'd0, 8'd4);
    cyc();
    set_inst(1'b1, 1'b1, 3'd2, 3'd0, 8'd4);
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b1 || uop_last_exe !== 1'b1) begin n_err++; $display("FAIL csr_c_uop got v=%b l=%b exp v=1 l=1", uop_valid_exe, uop_last_exe); end
    n_cmp++; if (riscv_v_stall !== 1'b1) begin n_err++; $display("FAIL csr_c_stall got %b exp 1", riscv_v_stall); end
    cyc();
    for (int j = 1; j <= 4; j++) begin
      smp();
      n_cmp++; if (riscv_v_stall !== (j < 4)) begin n_err++; $display("FAIL csr_stall C+%0d got %b exp %b", j, riscv_v_stall, (j < 4)); end
      n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL csr_no_uop C+%0d got %b exp 0", j, uop_valid_exe); end
      n_cmp++; if (dbg_state !== ((j == 1) ? ST_IDLE : ST_CSR_WAIT)) begin n_err++; $display("FAIL csr_state C+%0d got %0d exp %0d", j, dbg_state, ((j == 1) ? ST_IDLE : ST_CSR_WAIT)); end
      cyc();
    end
    inst_valid_id = 1'b0;
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b1) begin n_err++; $display("FAIL csr_c5_valid got %b exp 1", uop_valid_exe); end
    n_cmp++; if (uop_idx_exe !== 3'd0 || uop_last_exe !== 1'b1) begin n_err++; $display("FAIL csr_c5_uop got idx=%0d l=%b exp idx=0 l=1", uop_idx_exe, uop_last_exe); end
    cyc();
    // After a fully drained pipe a CSR write is accepted at once.
    for (int j = 0; j < 4; j++) cyc();
    set_inst(1'b1, 1'b1, 3'd2, 3'd0, 8'd4);
    smp();
    n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL csr_idle_stall got %b exp 0", riscv_v_stall); end
    cyc();
    inst_valid_id = 1'b0;
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b1) begin n_err++; $display("FAIL csr_idle_uop got %b exp 1", uop_valid_exe); end
    cyc();
  endtask

  // riscv_stall for 2 cycles on idx 1 of 4, then clear_pipe on idx 2.
  task automatic test_stall_clear();
    int   exp_i [5] = '{0, 1, 1, 1, 2};
    logic rs_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    set_inst(1'b1, 1'b0, 3'd0, 3'd2, 8'd64);
    cyc();
    inst_valid_id = 1'b0;
    for (int k = 0; k < 5; k++) begin
      riscv_stall = rs_v[k];
      clear_pipe  = (k == 4);
      smp();
      n_cmp++; if (uop_valid_exe !== 1'b1) begin n_err++; $display("FAIL hold_valid k=%0d got %b exp 1", k, uop_valid_exe); end
      n_cmp++; if (uop_idx_exe !== 3'(exp_i[k])) begin n_err++; $display("FAIL hold_idx k=%0d got %0d exp %0d", k, uop_idx_exe, exp_i[k]); end
      n_cmp++; if (riscv_v_stall !== 1'b1) begin n_err++; $display("FAIL hold_stall k=%0d got %b exp 1", k, riscv_v_stall); end
      cyc();
    end
    riscv_stall = 1'b0;
    clear_pipe  = 1'b0;
    // The flush also empties the drain counter, so a CSR write goes at once.
    set_inst(1'b1, 1'b1, 3'd0, 3'd2, 8'd64);
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL clear_valid got %b exp 0", uop_valid_exe); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL clear_state got %0d exp %0d", dbg_state, ST_IDLE); end
    n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL clear_csr_stall got %b exp 0", riscv_v_stall); end
    cyc();
    inst_valid_id = 1'b0;
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b1 || uop_last_exe !== 1'b1) begin n_err++; $display("FAIL clear_csr_uop got v=%b l=%b exp v=1 l=1", uop_valid_exe, uop_last_exe); end
    cyc();
  endtask

  // A: vsew=0 vlmul=1 vl=128 -> N=2 (capped by LMUL).
  // B: vsew=0 vlmul=2 vl=40 -> N=3, taken on A's last micro-op.
  task automatic test_back_to_back();
    int   exp_i [5] = '{0, 1, 0, 1, 2};
    logic exp_l [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    set_inst(1'b1, 1'b0, 3'd0, 3'd1, 8'd128);
    cyc();
    set_inst(1'b1, 1'b0, 3'd0, 3'd2, 8'd40);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) inst_valid_id = 1'b0;
      smp();
      n_cmp++; if (uop_valid_exe !== 1'b1) begin n_err++; $display("FAIL b2b_valid k=%0d got %b exp 1", k, uop_valid_exe); end
      n_cmp++; if (uop_idx_exe !== 3'(exp_i[k])) begin n_err++; $display("FAIL b2b_idx k=%0d got %0d exp %0d", k, uop_idx_exe, exp_i[k]); end
      n_cmp++; if (uop_last_exe !== exp_l[k]) begin n_err++; $display("FAIL b2b_last k=%0d got %b exp %b", k, uop_last_exe, exp_l[k]); end
      cyc();
    end
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL b2b_done got %b exp 0", uop_valid_exe); end
    cyc();
  endtask

  // vlmul=6 (fractional), then vsew=4 and vlmul=4 (illegal in both builds).
  task automatic test_illegal();
    logic [2:0] sew_v  [3] = '{3'd0, 3'd4, 3'd0};
    logic [2:0] lmul_v [3] = '{3'd6, 3'd0, 3'd4};
    logic       exp_ill;
    for (int t = 0; t < 3; t++) begin
`ifdef RISCV_V_FRAC_LMUL_EN
      exp_ill = (t != 0);
`else
      exp_ill = 1'b1;
`endif
      set_inst(1'b1, 1'b0, sew_v[t], lmul_v[t], 8'd16);
      smp();
      n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL ill_accept_stall t=%0d got %b exp 0", t, riscv_v_stall); end
      cyc();
      inst_valid_id = 1'b0;
      smp();
      n_cmp++; if (illegal_id !== exp_ill) begin n_err++; $display("FAIL ill_pulse t=%0d got %b exp %b", t, illegal_id, exp_ill); end
      n_cmp++; if (uop_valid_exe !== !exp_ill) begin n_err++; $display("FAIL ill_uop t=%0d got %b exp %b", t, uop_valid_exe, !exp_ill); end
      cyc();
      smp();
      n_cmp++; if (illegal_id !== 1'b0) begin n_err++; $display("FAIL ill_one_cycle t=%0d got %b exp 0", t, illegal_id); end
      n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL ill_after t=%0d got %b exp 0", t, uop_valid_exe); end
      cyc();
    end
  endtask

  // Asynchronous reset while idx 3 of 8 is presented.
  task automatic test_reset_mid();
    set_inst(1'b1, 1'b0, 3'd0, 3'd3, 8'd128);
    cyc();
    inst_valid_id = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    #2;
    n_cmp++; if (uop_idx_exe !== 3'd3) begin n_err++; $display("FAIL rmid_pre_idx got %0d exp 3", uop_idx_exe); end
    rst = 1'b0;
    #1;
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b exp 0", uop_valid_exe); end
    n_cmp++; if (uop_idx_exe !== 3'd0) begin n_err++; $display("FAIL rmid_idx got %0d exp 0", uop_idx_exe); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rmid_state got %0d exp %0d", dbg_state, ST_IDLE); end
    n_cmp++; if (riscv_v_stall !== 1'b0) begin n_err++; $display("FAIL rmid_stall got %b exp 0", riscv_v_stall); end
    cyc();
    rst = 1'b1;
    cyc();
    smp();
    n_cmp++; if (uop_valid_exe !== 1'b0) begin n_err++; $display("FAIL rmid_after got %b exp 0", uop_valid_exe); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_lmul8();
    test_partial_group();
    test_vl_zero();
    test_csr_drain();
    test_stall_clear();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
